mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined multiplier among NUM_IN requesters.
//   Requesters are granted round-robin into a single issue register. The
//   requester index travels with the operation in the LSBs of the multiplier
//   tag, and that index routes each result back to its requester.
//   The number of issued-but-unreturned operations is capped at MAX_INFLIGHT.
//   i_drain stops new grants and, once all work has returned, parks the block
//   in IDLE.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_*/o_req_rdy     per-requester operation handshake (flattened vectors)
//   o_rsp_*/i_rsp_rdy     per-requester result handshake (data/ctl shared)
//   o_mul_*/i_mul_rdy     issue handshake to the multiplier
//   i_mul_*/o_mul_rdy     result handshake from the multiplier
//   i_drain, o_idle       drain request and idle status
module mult_arbiter #(
    parameter int unsigned BITS         = 256,
    parameter int unsigned CTL_BITS     = 8,
    parameter int unsigned NUM_IN       = 4,
    parameter int unsigned MAX_INFLIGHT = 16,
    localparam int unsigned IDX_BITS    = $clog2(NUM_IN)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_IN-1:0]            i_req_val,
    input  logic [NUM_IN*BITS-1:0]       i_req_dat_a,
    input  logic [NUM_IN*BITS-1:0]       i_req_dat_b,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
    output logic [NUM_IN-1:0]            o_req_rdy,
    output logic [NUM_IN-1:0]            o_rsp_val,
    output logic [2*BITS-1:0]            o_rsp_dat,
    output logic [CTL_BITS-1:0]          o_rsp_ctl,
    input  logic [NUM_IN-1:0]            i_rsp_rdy,
    output logic                         o_mul_val,
    output logic [BITS-1:0]              o_mul_dat_a,
    output logic [BITS-1:0]              o_mul_dat_b,
    output logic [CTL_BITS+IDX_BITS-1:0] o_mul_ctl,
    input  logic                         i_mul_rdy,
    input  logic                         i_mul_val,
    input  logic [2*BITS-1:0]            i_mul_dat,
    input  logic [CTL_BITS+IDX_BITS-1:0] i_mul_ctl,
    output logic                         o_mul_rdy,
    input  logic                         i_drain,
    output logic                         o_idle
);

    localparam int unsigned TAG_BITS = CTL_BITS + IDX_BITS;
    localparam int unsigned CNT_BITS = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned IDX_EXT  = IDX_BITS + 1;

    localparam logic [CNT_BITS-1:0] MaxCnt   = CNT_BITS'(MAX_INFLIGHT);
    localparam logic [IDX_BITS-1:0] LastIdx  = IDX_BITS'(NUM_IN - 1);
    localparam logic [IDX_EXT-1:0]  NumInExt = IDX_EXT'(NUM_IN);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StIdle
    } state_e;

    state_e state_q, state_d;

    logic                mul_val_q, mul_val_d;
    logic [BITS-1:0]     mul_dat_a_q, mul_dat_b_q;
    logic [TAG_BITS-1:0] mul_ctl_q;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic [CNT_BITS-1:0] inflight_q, inflight_d;

    logic                slot_free;
    logic                issue_hs;
    logic                ret_hs;
    logic                cap_ok;
    logic                grant_en;
    logic                grant_vld;
    logic [IDX_BITS-1:0] grant_idx;
    logic [IDX_EXT-1:0]  cand;
    logic [BITS-1:0]     grant_a, grant_b;
    logic [CTL_BITS-1:0] grant_ctl;
    logic [IDX_BITS-1:0] rsp_idx;

    assign slot_free = ~mul_val_q | i_mul_rdy;
    assign issue_hs  = mul_val_q & i_mul_rdy;
    assign ret_hs    = i_mul_val & o_mul_rdy;

    // The cap includes the operation leaving the issue register this cycle, so a
    // new grant can never push the count past MAX_INFLIGHT once it issues.
    assign cap_ok = issue_hs ? (inflight_q < (MaxCnt - CNT_BITS'(1))) : (inflight_q < MaxCnt);

    // Reset gating keeps o_req_rdy low while i_rst_n is held low.
    assign grant_en = i_rst_n & slot_free & (state_q == StRun) & cap_ok;

    // Round-robin search starting at ptr_q, wrapping at NUM_IN.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant_a   = '0;
        grant_b   = '0;
        grant_ctl = '0;
        if (grant_en) begin
            for (int unsigned off = 0; off < NUM_IN; off++) begin
                cand = {1'b0, ptr_q} + IDX_EXT'(off);
                if (cand >= NumInExt) begin
                    cand = cand - NumInExt;
                end
                if (!grant_vld && i_req_val[cand[IDX_BITS-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[IDX_BITS-1:0];
                end
            end
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_idx == IDX_BITS'(i)) begin
                grant_a   = i_req_dat_a[i*BITS +: BITS];
                grant_b   = i_req_dat_b[i*BITS +: BITS];
                grant_ctl = i_req_ctl[i*CTL_BITS +: CTL_BITS];
            end
        end
    end

    always_comb begin
        o_req_rdy = '0;
        if (grant_vld) begin
            o_req_rdy[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        mul_val_d = mul_val_q;
        ptr_d     = ptr_q;
        if (slot_free) begin
            mul_val_d = grant_vld;
            if (grant_vld) begin
                ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + IDX_BITS'(1);
            end
        end
    end

    // Saturating in both directions: stale returns after a reset cannot underflow.
    always_comb begin
        inflight_d = inflight_q;
        if (issue_hs && !ret_hs && (inflight_q != '1)) begin
            inflight_d = inflight_q + CNT_BITS'(1);
        end else if (!issue_hs && ret_hs && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_BITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (i_drain) state_d = StDrain;
            end
            StDrain: begin
                if (!i_drain) begin
                    state_d = StRun;
                end else if ((inflight_q == '0) && !mul_val_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (!i_drain) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mul_val_q  <= 1'b0;
            ptr_q      <= '0;
            inflight_q <= '0;
            state_q    <= StRun;
        end else begin
            mul_val_q  <= mul_val_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            state_q    <= state_d;
        end
    end

    // Payload is qualified by mul_val_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (grant_vld) begin
            mul_dat_a_q <= grant_a;
            mul_dat_b_q <= grant_b;
            mul_ctl_q   <= {grant_ctl, grant_idx};
        end
    end

    assign o_mul_val   = mul_val_q;
    assign o_mul_dat_a = mul_dat_a_q;
    assign o_mul_dat_b = mul_dat_b_q;
    assign o_mul_ctl   = mul_ctl_q;

    // Result routing by the index in the tag LSBs. Tags naming a nonexistent
    // requester are accepted and dropped so the multiplier cannot stall on them.
    assign rsp_idx = i_mul_ctl[IDX_BITS-1:0];

    always_comb begin
        o_rsp_val = '0;
        o_mul_rdy = 1'b1;
        if ({1'b0, rsp_idx} < NumInExt) begin
            o_rsp_val[rsp_idx] = i_mul_val;
            o_mul_rdy          = i_rsp_rdy[rsp_idx];
        end
    end

    assign o_rsp_dat = i_mul_dat;
    assign o_rsp_ctl = i_mul_ctl[TAG_BITS-1:IDX_BITS];

    assign o_idle = (state_q == StIdle) ||
                    ((state_q == StRun) && (inflight_q == '0) && !mul_val_q && (i_req_val == '0));

endmodule
